// File: rtl/mdom_wvb_conf_shadow_if.sv
// Config write bus into the waveform-buffer config shadow.
//   bundle       : packed config (cnst_conf, test_conf, post_conf, pre_conf,
//                  arm, trig_mode, cnst_run from LSB to MSB)
//   bundle_valid : one-cycle write strobe
//   chan_mask    : channels written by this strobe
// master drives the bus (register/command side), slave receives it.
interface mdom_wvb_conf_shadow_if #(
  parameter int unsigned N_CHAN = 24,
  parameter int unsigned BW     = 40
);
  logic [BW-1:0]     bundle;
  logic              bundle_valid;
  logic [N_CHAN-1:0] chan_mask;

  modport master (output bundle, output bundle_valid, output chan_mask);
  modport slave  (input  bundle, input  bundle_valid, input  chan_mask);
endinterface

// File: rtl/mdom_wvb_conf_shadow.sv
// Multi-channel double-buffered waveform-buffer config shadow.
// Each channel latches writes into a pending register and promotes them to
// the active register once its waveform buffer is idle; it also produces an
// arm strobe on promotion and a periodic constant-run trigger.
// Ports:
//   clk, rst     : clock, async active-high reset
//   cfg_bus      : write bus (bundle, bundle_valid, chan_mask), slave side
//   wvb_busy     : per-channel buffer capturing, blocks promotion
//   cnst_conf, test_conf, post_conf, pre_conf, trig_mode : active fields,
//                  channel 0 in LSBs
//   arm_pulse    : one-cycle arm strobe per channel
//   cnst_trig    : one-cycle constant-run trigger per channel
//   pending      : channel holds an unpromoted config
// Optional macro MDOM_WVB_CONF_READBACK_EN adds rd_chan / rd_bundle readback
// of the active config (arm bit reads 0, 1-cycle latency).
module mdom_wvb_conf_shadow #(
  parameter int unsigned N_CHAN = 24,
  parameter int unsigned CNST_W = 12,
  parameter int unsigned TEST_W = 12,
  parameter int unsigned POST_W = 8,
  parameter int unsigned PRE_W  = 5,
  localparam int unsigned BW    = CNST_W + TEST_W + POST_W + PRE_W + 3
) (
  input  logic                       clk,
  input  logic                       rst,
  mdom_wvb_conf_shadow_if.slave      cfg_bus,
  input  logic [N_CHAN-1:0]          wvb_busy,
  output logic [N_CHAN*CNST_W-1:0]   cnst_conf,
  output logic [N_CHAN*TEST_W-1:0]   test_conf,
  output logic [N_CHAN*POST_W-1:0]   post_conf,
  output logic [N_CHAN*PRE_W-1:0]    pre_conf,
  output logic [N_CHAN-1:0]          trig_mode,
  output logic [N_CHAN-1:0]          arm_pulse,
  output logic [N_CHAN-1:0]          cnst_trig,
  output logic [N_CHAN-1:0]          pending
`ifdef MDOM_WVB_CONF_READBACK_EN
  ,
  input  logic [$clog2(N_CHAN)-1:0]  rd_chan,
  output logic [BW-1:0]              rd_bundle
`endif
);

  typedef struct packed {
    logic              cnst_run;
    logic              trig_mode;
    logic              arm;
    logic [PRE_W-1:0]  pre;
    logic [POST_W-1:0] post;
    logic [TEST_W-1:0] test;
    logic [CNST_W-1:0] cnst;
  } cfg_t;

  // Active copy carries no arm bit: arm only ever exists as a pulse.
  typedef struct packed {
    logic              cnst_run;
    logic              trig_mode;
    logic [PRE_W-1:0]  pre;
    logic [POST_W-1:0] post;
    logic [TEST_W-1:0] test;
    logic [CNST_W-1:0] cnst;
  } act_t;

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

  cfg_t              wr_cfg;
  state_t            state_q [N_CHAN];
  state_t            state_d [N_CHAN];
  logic [N_CHAN-1:0] wr_c;
  logic [N_CHAN-1:0] promote_c;
  cfg_t              pend_q  [N_CHAN];
  act_t              act_q   [N_CHAN];
  logic [CNST_W-1:0] cnt_q   [N_CHAN];

  assign wr_cfg = cfg_bus.bundle;

  // Per-channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHAN; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int unsigned i = 0; i < N_CHAN; i++) state_q[i] <= state_d[i];
    end
  end

  // Next state; a write in the promotion cycle wins and defers promotion.
  always_comb begin
    wr_c      = '0;
    promote_c = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      state_d[i]   = state_q[i];
      wr_c[i]      = cfg_bus.bundle_valid & cfg_bus.chan_mask[i];
      promote_c[i] = (state_q[i] == S_PEND) && !wvb_busy[i] &&
                     !(cfg_bus.bundle_valid && cfg_bus.chan_mask[i]);
      if (cfg_bus.bundle_valid && cfg_bus.chan_mask[i]) begin
        state_d[i] = S_PEND;
      end else if (promote_c[i]) begin
        state_d[i] = S_IDLE;
      end
    end
  end

  // Pending/active registers, arm strobe and constant-run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_pulse <= '0;
      cnst_trig <= '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (wr_c[i]) pend_q[i] <= wr_cfg;
        arm_pulse[i] <= promote_c[i] & pend_q[i].arm;
        if (promote_c[i]) begin
          act_q[i].cnst_run  <= pend_q[i].cnst_run;
          act_q[i].trig_mode <= pend_q[i].trig_mode;
          act_q[i].pre       <= pend_q[i].pre;
          act_q[i].post      <= pend_q[i].post;
          act_q[i].test      <= pend_q[i].test;
          act_q[i].cnst      <= pend_q[i].cnst;
          cnt_q[i]           <= '0;
          cnst_trig[i]       <= 1'b0;
        end else if (!act_q[i].cnst_run) begin
          cnt_q[i]     <= '0;
          cnst_trig[i] <= 1'b0;
        end else if (cnt_q[i] == act_q[i].cnst) begin
          cnt_q[i]     <= '0;
          cnst_trig[i] <= 1'b1;
        end else begin
          cnt_q[i]     <= cnt_q[i] + CNST_W'(1);
          cnst_trig[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten the active registers onto the output buses.
  always_comb begin
    cnst_conf = '0;
    test_conf = '0;
    post_conf = '0;
    pre_conf  = '0;
    trig_mode = '0;
    pending   = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      cnst_conf[i*CNST_W +: CNST_W] = act_q[i].cnst;
      test_conf[i*TEST_W +: TEST_W] = act_q[i].test;
      post_conf[i*POST_W +: POST_W] = act_q[i].post;
      pre_conf[i*PRE_W +: PRE_W]    = act_q[i].pre;
      trig_mode[i]                  = act_q[i].trig_mode;
      pending[i]                    = (state_q[i] == S_PEND);
    end
  end

`ifdef MDOM_WVB_CONF_READBACK_EN
  // Registered readback; out-of-range channels read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bundle <= '0;
    end else if (32'(rd_chan) < N_CHAN) begin
      rd_bundle <= {act_q[rd_chan].cnst_run, act_q[rd_chan].trig_mode, 1'b0,
                    act_q[rd_chan].pre, act_q[rd_chan].post,
                    act_q[rd_chan].test, act_q[rd_chan].cnst};
    end else begin
      rd_bundle <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mdom_wvb_conf_shadow.sv
// Testbench for mdom_wvb_conf_shadow: table of per-cycle vectors with
// hand-computed expectations, plus hand sequences for readback and reset.
module tb_mdom_wvb_conf_shadow;
  localparam int unsigned N_CHAN = 24;
  localparam int unsigned BW     = 40;
  localparam int unsigned NV     = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N_CHAN-1:0]    wvb_busy;
  logic [N_CHAN*12-1:0] cnst_conf;
  logic [N_CHAN*12-1:0] test_conf;
  logic [N_CHAN*8-1:0]  post_conf;
  logic [N_CHAN*5-1:0]  pre_conf;
  logic [N_CHAN-1:0]    trig_mode;
  logic [N_CHAN-1:0]    arm_pulse;
  logic [N_CHAN-1:0]    cnst_trig;
  logic [N_CHAN-1:0]    pending;
`ifdef MDOM_WVB_CONF_READBACK_EN
  logic [4:0]           rd_chan;
  logic [BW-1:0]        rd_bundle;
`endif

  int n_checks = 0;
  int n_err    = 0;

  mdom_wvb_conf_shadow_if #(.N_CHAN(N_CHAN), .BW(BW)) cfg_bus ();

  mdom_wvb_conf_shadow dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bus   (cfg_bus),
    .wvb_busy  (wvb_busy),
    .cnst_conf (cnst_conf),
    .test_conf (test_conf),
    .post_conf (post_conf),
    .pre_conf  (pre_conf),
    .trig_mode (trig_mode),
    .arm_pulse (arm_pulse),
    .cnst_trig (cnst_trig),
    .pending   (pending)
`ifdef MDOM_WVB_CONF_READBACK_EN
    ,
    .rd_chan   (rd_chan),
    .rd_bundle (rd_bundle)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [N_CHAN-1:0] mask;
    logic [BW-1:0]     bdl;
    logic [N_CHAN-1:0] busy;
    int                ch;
    logic [N_CHAN-1:0] e_pend;
    logic [N_CHAN-1:0] e_arm;
    logic [N_CHAN-1:0] e_trig;
    logic [BW-1:0]     e_act;   // expected active fields of ch, bundle format
  } vec_t;

  vec_t vt [NV];

  function automatic logic [BW-1:0] mk(input logic [11:0] cn, input logic [11:0] te,
                                       input logic [7:0] po, input logic [4:0] pr,
                                       input logic arm, input logic tm, input logic run);
    return {run, tm, arm, pr, po, te, cn};
  endfunction

  function automatic vec_t v(input logic valid, input logic [N_CHAN-1:0] mask,
                             input logic [BW-1:0] bdl, input logic [N_CHAN-1:0] busy,
                             input int ch, input logic [N_CHAN-1:0] e_pend,
                             input logic [N_CHAN-1:0] e_arm, input logic [N_CHAN-1:0] e_trig,
                             input logic [BW-1:0] e_act);
    vec_t r;
    r.valid = valid; r.mask = mask; r.bdl = bdl; r.busy = busy; r.ch = ch;
    r.e_pend = e_pend; r.e_arm = e_arm; r.e_trig = e_trig; r.e_act = e_act;
    return r;
  endfunction

  function automatic logic [N_CHAN-1:0] bit_of(input int n);
    return N_CHAN'(1) << n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] b1, p3, t1, t2, bx, by, c3, c0, r0, ex;

  initial begin
    b1 = mk(12'h005, 12'h000, 8'h10, 5'h00, 1'b1, 1'b0, 1'b0);
    p3 = mk(12'h000, 12'h000, 8'h00, 5'h07, 1'b0, 1'b0, 1'b0);
    t1 = mk(12'h000, 12'h111, 8'h00, 5'h00, 1'b0, 1'b0, 1'b0);
    t2 = mk(12'h000, 12'h222, 8'h00, 5'h00, 1'b0, 1'b0, 1'b0);
    bx = mk(12'hABC, 12'h123, 8'h45, 5'h1F, 1'b1, 1'b1, 1'b0);
    by = mk(12'h0A5, 12'h3C3, 8'h5A, 5'h0A, 1'b0, 1'b1, 1'b0);
    c3 = mk(12'h003, 12'h000, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1);
    c0 = mk(12'h000, 12'h000, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1);
    r0 = '0;

    // Each row: inputs held for one cycle, expectations sampled just after the edge.
    // Write ch0, idle: pending next cycle, active + arm pulse the cycle after.
    vt[0]  = v(1, bit_of(0), b1, '0,        0, bit_of(0), '0, '0, r0);
    vt[1]  = v(0, '0, r0, '0,               0, '0, bit_of(0), '0, b1);
    vt[2]  = v(0, '0, r0, '0,               0, '0, '0, '0, b1);
    // Busy deferral on ch3.
    vt[3]  = v(1, bit_of(3), p3, bit_of(3), 3, bit_of(3), '0, '0, r0);
    vt[4]  = v(0, '0, r0, bit_of(3),        3, bit_of(3), '0, '0, r0);
    vt[5]  = v(0, '0, r0, '0,               3, '0, '0, '0, p3);
    // Overwrite while pending on ch5: 0x111 must never become active.
    vt[6]  = v(1, bit_of(5), t1, bit_of(5), 5, bit_of(5), '0, '0, r0);
    vt[7]  = v(1, bit_of(5), t2, bit_of(5), 5, bit_of(5), '0, '0, r0);
    vt[8]  = v(0, '0, r0, bit_of(5),        5, bit_of(5), '0, '0, r0);
    vt[9]  = v(0, '0, r0, '0,               5, '0, '0, '0, t2);
    // Busy drops in the same cycle as a new write to ch2.
    vt[10] = v(1, bit_of(2), bx, bit_of(2), 2, bit_of(2), '0, '0, r0);
    vt[11] = v(1, bit_of(2), by, '0,        2, bit_of(2), '0, '0, r0);
    vt[12] = v(0, '0, r0, '0,               2, '0, '0, '0, by);
    // Constant run on ch1, period 4.
    vt[13] = v(1, bit_of(1), c3, '0,        1, bit_of(1), '0, '0, r0);
    vt[14] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[15] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[16] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[17] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[18] = v(0, '0, r0, '0,               1, '0, '0, bit_of(1), c3);
    vt[19] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[20] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[21] = v(0, '0, r0, '0,               1, '0, '0, '0, c3);
    vt[22] = v(0, '0, r0, '0,               1, '0, '0, bit_of(1), c3);
    // cnst_conf=0: trigger every cycle once active.
    vt[23] = v(1, bit_of(1), c0, '0,        1, bit_of(1), '0, '0, c3);
    vt[24] = v(0, '0, r0, '0,               1, '0, '0, '0, c0);
    vt[25] = v(0, '0, r0, '0,               1, '0, '0, bit_of(1), c0);
    vt[26] = v(0, '0, r0, '0,               1, '0, '0, bit_of(1), c0);
    vt[27] = v(0, '0, r0, '0,               1, '0, '0, bit_of(1), c0);
    // cnst_run=0 stops triggers from promotion onwards.
    vt[28] = v(1, bit_of(1), r0, '0,        1, bit_of(1), '0, bit_of(1), c0);
    vt[29] = v(0, '0, r0, '0,               1, '0, '0, '0, r0);
    vt[30] = v(0, '0, r0, '0,               1, '0, '0, '0, r0);
    vt[31] = v(0, '0, r0, '0,               1, '0, '0, '0, r0);

    rst = 1'b1;
    wvb_busy = '0;
    cfg_bus.bundle = '0;
    cfg_bus.bundle_valid = 1'b0;
    cfg_bus.chan_mask = '0;
`ifdef MDOM_WVB_CONF_READBACK_EN
    rd_chan = '0;
`endif
    repeat (3) tick();

    chk("rst pending",   64'(pending),   64'h0);
    chk("rst arm_pulse", 64'(arm_pulse), 64'h0);
    chk("rst cnst_trig", 64'(cnst_trig), 64'h0);
    chk("rst trig_mode", 64'(trig_mode), 64'h0);
    chk("rst fields", 64'({|cnst_conf, |test_conf, |post_conf, |pre_conf}), 64'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < int'(NV); i++) begin
      cfg_bus.bundle_valid = vt[i].valid;
      cfg_bus.chan_mask    = vt[i].mask;
      cfg_bus.bundle       = vt[i].bdl;
      wvb_busy             = vt[i].busy;
      tick();
      ex = vt[i].e_act;
      chk($sformatf("row%0d pending", i),   64'(pending),   64'(vt[i].e_pend));
      chk($sformatf("row%0d arm_pulse", i), 64'(arm_pulse), 64'(vt[i].e_arm));
      chk($sformatf("row%0d cnst_trig", i), 64'(cnst_trig), 64'(vt[i].e_trig));
      chk($sformatf("row%0d ch%0d cnst", i, vt[i].ch), 64'(cnst_conf[vt[i].ch*12 +: 12]), 64'(ex[11:0]));
      chk($sformatf("row%0d ch%0d test", i, vt[i].ch), 64'(test_conf[vt[i].ch*12 +: 12]), 64'(ex[23:12]));
      chk($sformatf("row%0d ch%0d post", i, vt[i].ch), 64'(post_conf[vt[i].ch*8 +: 8]),   64'(ex[31:24]));
      chk($sformatf("row%0d ch%0d pre", i, vt[i].ch),  64'(pre_conf[vt[i].ch*5 +: 5]),    64'(ex[36:32]));
      chk($sformatf("row%0d ch%0d tmode", i, vt[i].ch), 64'(trig_mode[vt[i].ch]),         64'(ex[38]));
    end
    cfg_bus.bundle_valid = 1'b0;
    cfg_bus.chan_mask    = '0;
    wvb_busy             = '0;

    // Earlier channels must still hold their configs.
    chk("hold ch0 post", 64'(post_conf[0*8 +: 8]),   64'h10);
    chk("hold ch3 pre",  64'(pre_conf[3*5 +: 5]),    64'h07);
    chk("hold ch5 test", 64'(test_conf[5*12 +: 12]), 64'h222);
    chk("hold ch2 cnst", 64'(cnst_conf[2*12 +: 12]), 64'h0A5);

`ifdef MDOM_WVB_CONF_READBACK_EN
    rd_chan = 5'd2;
    tick();
    chk("rd ch2", 64'(rd_bundle), 64'(mk(12'h0A5, 12'h3C3, 8'h5A, 5'h0A, 1'b0, 1'b1, 1'b0)));
    rd_chan = 5'd0;
    tick();
    chk("rd ch0 arm cleared", 64'(rd_bundle), 64'(mk(12'h005, 12'h000, 8'h10, 5'h00, 1'b0, 1'b0, 1'b0)));
    rd_chan = 5'd30;
    tick();
    chk("rd ch30", 64'(rd_bundle), 64'h0);
`endif

    // Reset mid-operation discards a pending config.
    wvb_busy = bit_of(4);
    cfg_bus.bundle = mk(12'h000, 12'h000, 8'h77, 5'h00, 1'b1, 1'b0, 1'b0);
    cfg_bus.chan_mask = bit_of(4);
    cfg_bus.bundle_valid = 1'b1;
    tick();
    cfg_bus.bundle_valid = 1'b0;
    chk("mid pending", 64'(pending), 64'(bit_of(4)));
    #2 rst = 1'b1;
    #1;
    chk("async rst pending", 64'(pending), 64'h0);
    chk("async rst fields", 64'({|cnst_conf, |test_conf, |post_conf, |pre_conf, |trig_mode}), 64'h0);
    tick();
    rst = 1'b0;
    wvb_busy = '0;
    tick();
    tick();
    chk("post rst pending", 64'(pending), 64'h0);
    chk("post rst ch4 post", 64'(post_conf[4*8 +: 8]), 64'h0);
    chk("post rst arm", 64'(arm_pulse), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
